// File: rtl/dec_convert_ctrl.sv
// dec_convert_ctrl: converts a 32-bit unsigned value into up to 16 ASCII
// digits in radix 2..16. It produces one digit per clock, least-significant
// digit first, and hands the result off with a valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; result keeps the last value
// CONV  | one digit per cycle from the latched quotient q and radix b
// DONE  | result/err held with out_valid until the consumer accepts
module dec_convert_ctrl (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [31:0]  i_decimal,
  input  logic [4:0]   i_base,
  output logic         o_busy,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_result,
  output logic         o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [127:0] BLANK = {16{8'h20}};

  state_t       r_state;
  logic [31:0]  r_q;
  logic [4:0]   r_b;
  logic [4:0]   r_cnt;
  logic [127:0] r_result;
  logic         r_err;
  logic         r_busy;
  logic         r_out_valid;

  logic [31:0]  w_divisor;
  logic [31:0]  w_quot;
  logic [31:0]  w_rem;
  logic [7:0]   w_ascii;
  logic         w_base_ok;

  // Divider and digit encoder work only on the latched q and b.
  always_comb begin
    w_divisor = {27'd0, r_b};
    w_quot    = r_q / w_divisor;
    w_rem     = r_q % w_divisor;
    // 0x37 + 10 = 'A', so remainders 10..15 become uppercase letters.
    w_ascii   = (w_rem < 32'd10) ? (8'h30 + w_rem[7:0]) : (8'h37 + w_rem[7:0]);
    w_base_ok = (i_base >= 5'd2) && (i_base <= 5'd16);
  end

  // Single-process FSM with registered outputs. Reset overrides every transition.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_q         <= 32'd0;
      r_b         <= 5'd0;
      r_cnt       <= 5'd0;
      r_result    <= BLANK;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_result <= BLANK;
            if (w_base_ok) begin
              r_q     <= i_decimal;
              r_b     <= i_base;
              r_cnt   <= 5'd0;
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_CONV;
            end else begin
              // Bad radix skips conversion entirely and reports at once.
              r_err       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end

        S_CONV: begin
          r_result[{r_cnt[3:0], 3'b000} +: 8] <= w_ascii;
          r_q   <= w_quot;
          r_cnt <= r_cnt + 5'd1;
          if (w_quot == 32'd0) begin
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_cnt == 5'd15) begin
            // Sixteenth digit written but value not exhausted: overflow.
            r_err       <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_err       = r_err;

endmodule

// File: doc/dec_convert_ctrl.md
DEC_CONVERT_CTRL -- requirements
Module: dec_convert_ctrl

Interface
REQ-001 Parameter: none; all widths are fixed.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request: convert `decimal` in radix `base`; sampled only in IDLE.
REQ-005 decimal  input  32  unsigned value to convert; latched on accepted start.
REQ-006 base  input  5  radix; valid range 2..16; latched on accepted start.
REQ-007 busy  output  1  high while in CONV.
REQ-008 out_valid  output  1  high in DONE; result/err stable while high.
REQ-009 out_ready  input  1  consumer accept; transfer completes when out_valid && out_ready.
REQ-010 result  output  128  16 ASCII chars; char i occupies bits [8i+7:8i]; char 0 holds the least-significant digit.
REQ-011 err  output  1  high with out_valid when base is invalid or there is digit overflow.

Function
REQ-012 FSM states SHALL be IDLE, CONV and DONE, and no others.
REQ-013 IDLE, start=1, base in 2..16:
- latch decimal into quotient register q and base into b;
- fill result with 0x20;
- clear the digit counter cnt (5 bits) and err;
- go to CONV.
REQ-014 IDLE, start=1, base outside 2..16: fill result with 0x20, set err=1, go to DONE.
REQ-015 CONV, one digit per cycle:
- r = q mod b;
- write ASCII(r) into char cnt;
- q <= q / b;
- cnt <= cnt+1.
REQ-016 ASCII mapping: r 0..9 -> 0x30+r; r 10..15 -> 0x41+(r-10), uppercase.
REQ-017 CONV exit, normal: when the new q == 0, go to DONE with err=0.
REQ-018 CONV exit, overflow: when a 16th digit is written and the new q != 0, go to DONE with err=1, keeping the 16 digits written.
REQ-019 Input value 0 SHALL produce exactly one digit, '0' (0x30), in char 0.
REQ-020 Latency, valid base: out_valid SHALL assert d clock edges after the edge that accepts start, where d = digit count (d >= 1).
REQ-021 Latency, invalid base: out_valid SHALL assert on the edge that samples start.
REQ-022 DONE handshake:
- hold out_valid, result and err until out_valid && out_ready;
- on that edge go to IDLE and deassert out_valid;
- result keeps its last value in IDLE.
REQ-023 start SHALL be ignored in CONV and DONE; it is neither queued nor counted.
REQ-024 Changes to decimal or base after start is accepted SHALL NOT affect the conversion in progress.
REQ-025 Division and modulo SHALL use only the latched q and b; q is 32-bit unsigned; no signed interpretation.
REQ-026 Back-to-back operation: a start in the IDLE cycle immediately after a DONE transfer SHALL be accepted; IDLE has no mandatory idle cycles.

Reset
REQ-027 rst_n=0 at a clock edge SHALL set: state IDLE, busy=0, out_valid=0, err=0, result all 0x20, q=0, b=0, cnt=0.
REQ-028 Reset SHALL take priority over every transition, including mid-CONV and DONE with out_ready=1; a partial result is discarded.
REQ-029 The first start SHALL be honoured on the first edge with rst_n=1.

Verification
REQ-030 decimal=10, base=2, start pulse, out_ready=1 -> busy for 4 cycles; out_valid after 4 edges; chars 3..0 = "1010"; chars 15..4 = 0x20; err=0.
REQ-031 decimal=255, base=16 -> result low chars "FF" after 2 edges; decimal=500, base=10 -> "500" after 3 edges; err=0.
REQ-032 decimal=50, base=1, then base=0 and base=17 -> out_valid the cycle after start; err=1; result all 0x20; busy never high.
REQ-033 decimal=0, base=2 -> char 0 = 0x30 after 1 edge. decimal=0xFFFFFFFF, base=2 -> after 16 edges: err=1, 16 chars '1'.
REQ-034 out_ready=0 for 5 cycles in DONE, start pulsed meanwhile -> out_valid, result and err held; no new conversion; one transfer when out_ready=1.
REQ-035 rst_n=0 during CONV of 500/base 10 after 1 digit -> next cycle IDLE, all outputs at reset values; a new start converts correctly.
